// File: rtl/decode_pkg.sv
// Shared types and field-decode helpers for the instruction decode stage.
// Records are sized to the largest supported widths; the top trims them to its parameters.
package decode_pkg;
    localparam int OP_W = 4;
    localparam logic [1:0] BRANCH_OP1_PREFIX = 2'b01;
    localparam int MAX_INSTR_W = 64;
    localparam int MAX_REG_W = 8;
    localparam int MAX_DATA_W = 64;
    localparam int IDX_W = $clog2(MAX_INSTR_W);

    typedef struct packed {
        logic [OP_W-1:0]       op1;
        logic [OP_W-1:0]       op2;
        logic [MAX_REG_W-1:0]  rd;
        logic [MAX_REG_W-1:0]  rs1;
        logic [MAX_REG_W-1:0]  rs2;
        logic [MAX_DATA_W-1:0] imm;
        logic                  is_branch;
    } decoded_t;

    function automatic int op1_lsb(input int w);
        return w - OP_W;
    endfunction

    function automatic int op2_lsb(input int w);
        return w - 2 * OP_W;
    endfunction

    // idx 0/1/2 selects register fields A/B/C, packed downward below op2.
    function automatic int field_lsb(input int w, input int r, input int idx);
        return w - 2 * OP_W - (idx + 1) * r;
    endfunction

    function automatic logic [MAX_DATA_W-1:0] low_mask(input int n);
        logic [MAX_DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_DATA_W; i++)
            if (i < n) m[i] = 1'b1;
        return m;
    endfunction

    function automatic decoded_t decode_fields(input logic [MAX_INSTR_W-1:0] instr,
                                               input int w, input int r, input int immw,
                                               input int dw, input int brs);
        decoded_t d;
        logic [MAX_REG_W-1:0] rmask, fa, fb, fc;
        logic [MAX_DATA_W-1:0] imask, imm;
        logic sgn;
        rmask = MAX_REG_W'(low_mask(r));
        imask = low_mask(immw);
        d.op1 = OP_W'(instr >> op1_lsb(w));
        d.op2 = OP_W'(instr >> op2_lsb(w));
        fa = MAX_REG_W'(instr >> field_lsb(w, r, 0)) & rmask;
        fb = MAX_REG_W'(instr >> field_lsb(w, r, 1)) & rmask;
        fc = MAX_REG_W'(instr >> field_lsb(w, r, 2)) & rmask;
        d.is_branch = (d.op1[OP_W-1 -: 2] == BRANCH_OP1_PREFIX);
        d.rd  = fa;
        d.rs1 = d.is_branch ? fa : fb;
        d.rs2 = d.is_branch ? fb : fc;
        sgn = instr[IDX_W'(immw - 1)];
        imm = MAX_DATA_W'(instr) & imask;
        if (sgn) imm = imm | ~imask;
        if (d.is_branch) imm = imm << brs;
        d.imm = imm & low_mask(dw);
        return d;
    endfunction
endpackage

// File: rtl/decode_skid.sv
// Two-entry skid buffer of decoded records: entry 0 drives the outputs, entry 1 absorbs
// the one extra beat that arrives while ready is still registered high.
module decode_skid
    import decode_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     flush,
    input  logic     in_valid,
    output logic     in_ready,
    input  decoded_t in_data,
    output logic     out_valid,
    input  logic     out_ready,
    output decoded_t out_data
);
    logic     v0, v1, rdy;
    decoded_t d0, d1;
    logic     in_xfer, out_xfer, v1_next;

    assign in_xfer   = in_valid && rdy;
    assign out_xfer  = v0 && out_ready;
    assign in_ready  = rdy;
    assign out_valid = v0;
    assign out_data  = d0;

    // Entry 1 only ever fills while entry 0 is held, so v1 implies v0.
    always_comb begin
        v1_next = v1;
        if (flush)   v1_next = 1'b0;
        else if (v1) v1_next = !out_xfer;
        else         v1_next = v0 && !out_xfer && in_xfer;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v0  <= 1'b0;
            v1  <= 1'b0;
            rdy <= 1'b0;
            d0  <= '0;
            d1  <= '0;
        end else begin
            rdy <= !v1_next;
            v1  <= v1_next;
            if (!v1 && v1_next) d1 <= in_data;
            if (flush) begin
                v0 <= 1'b0;
            end else if (!v0 || out_xfer) begin
                if (v1) begin
                    d0 <= d1;
                    v0 <= 1'b1;
                end else if (in_xfer) begin
                    d0 <= in_data;
                    v0 <= 1'b1;
                end else begin
                    v0 <= 1'b0;
                end
            end
        end
    end
endmodule

// File: rtl/decode_stage.sv
// Registered instruction-decode stage: decodes on input, buffers the decoded record in a
// two-entry skid buffer, and counts completed output transfers.
module decode_stage #(
    parameter int INSTR_WIDTH = 32,
    parameter int REG_WIDTH   = 4,
    parameter int IMM_WIDTH   = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int BR_SHIFT    = 2,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_WIDTH-1:0] in_instr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [3:0]             out_op1,
    output logic [3:0]             out_op2,
    output logic [REG_WIDTH-1:0]   out_rd,
    output logic [REG_WIDTH-1:0]   out_rs1,
    output logic [REG_WIDTH-1:0]   out_rs2,
    output logic [DATA_WIDTH-1:0]  out_imm,
    output logic                   out_is_branch,
    output logic [COUNT_WIDTH-1:0] out_count
);
    import decode_pkg::*;

    if (INSTR_WIDTH < 2 * OP_W + 3 * REG_WIDTH) begin : g_chk_instr
        $fatal(1, "INSTR_WIDTH too small for opcode and register fields");
    end
    if (IMM_WIDTH > DATA_WIDTH || IMM_WIDTH < 1) begin : g_chk_imm
        $fatal(1, "IMM_WIDTH must be in 1..DATA_WIDTH");
    end
    if (INSTR_WIDTH > MAX_INSTR_W || REG_WIDTH > MAX_REG_W || DATA_WIDTH > MAX_DATA_W) begin : g_chk_max
        $fatal(1, "width exceeds decode_pkg record limits");
    end

    decoded_t dec_in, dec_out;
    logic     unused_dec;

    assign dec_in = decode_fields(MAX_INSTR_W'(in_instr), INSTR_WIDTH, REG_WIDTH,
                                  IMM_WIDTH, DATA_WIDTH, BR_SHIFT);

    decode_skid u_skid (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (dec_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (dec_out)
    );

    // Record carries max-width fields; only the low parameterised bits leave the stage.
    assign unused_dec    = ^dec_out;
    assign out_op1       = dec_out.op1;
    assign out_op2       = dec_out.op2;
    assign out_rd        = dec_out.rd[REG_WIDTH-1:0];
    assign out_rs1       = dec_out.rs1[REG_WIDTH-1:0];
    assign out_rs2       = dec_out.rs2[REG_WIDTH-1:0];
    assign out_imm       = dec_out.imm[DATA_WIDTH-1:0];
    assign out_is_branch = dec_out.is_branch;

    always_ff @(posedge clk) begin
        if (reset)                       out_count <= '0;
        else if (out_valid && out_ready) out_count <= out_count + COUNT_WIDTH'(1);
    end
endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench: directed vectors on a default-width stage with a 4-bit counter, then
// a random stream on a REG_WIDTH=5 / IMM_WIDTH=9 stage against a slice-based reference.
module tb_decode_stage;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0]  op1, op2;
        logic [7:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic        br;
    } exp_t;

    // Instance A: default widths, 4-bit counter.
    logic        a_reset, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_is_branch;
    logic [31:0] a_in_instr, a_imm;
    logic [3:0]  a_op1, a_op2, a_rd, a_rs1, a_rs2, a_count;

    decode_stage #(.COUNT_WIDTH(4)) u_dut_a (
        .clk(clk), .reset(a_reset), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_instr(a_in_instr),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_op1(a_op1), .out_op2(a_op2), .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2),
        .out_imm(a_imm), .out_is_branch(a_is_branch), .out_count(a_count)
    );

    // Instance B: 5-bit register fields, 9-bit immediate.
    logic        b_reset, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_is_branch;
    logic [31:0] b_in_instr, b_imm;
    logic [3:0]  b_op1, b_op2;
    logic [4:0]  b_rd, b_rs1, b_rs2;
    logic [15:0] b_count;

    decode_stage #(.REG_WIDTH(5), .IMM_WIDTH(9)) u_dut_b (
        .clk(clk), .reset(b_reset), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_op1(b_op1), .out_op2(b_op2), .out_rd(b_rd), .out_rs1(b_rs1), .out_rs2(b_rs2),
        .out_imm(b_imm), .out_is_branch(b_is_branch), .out_count(b_count)
    );

    exp_t qa[$];
    exp_t qb[$];
    exp_t a_e, b_e, dummy;
    logic [3:0]  a_cnt_exp = 4'd0;
    logic [15:0] b_cnt_exp = 16'd0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_rec(input string p, input exp_t e, input logic [3:0] op1, input logic [3:0] op2,
                           input logic [7:0] rd, input logic [7:0] rs1, input logic [7:0] rs2,
                           input logic [31:0] imm, input logic br);
        chk({p, "_op1"}, 64'(op1), 64'(e.op1));
        chk({p, "_op2"}, 64'(op2), 64'(e.op2));
        chk({p, "_rd"},  64'(rd),  64'(e.rd));
        chk({p, "_rs1"}, 64'(rs1), 64'(e.rs1));
        chk({p, "_rs2"}, 64'(rs2), 64'(e.rs2));
        chk({p, "_imm"}, 64'(imm), 64'(e.imm));
        chk({p, "_br"},  64'(br),  64'(e.br));
    endtask

    function automatic exp_t mk(input logic [3:0] op1, input logic [3:0] op2, input logic [7:0] rd,
                                input logic [7:0] rs1, input logic [7:0] rs2,
                                input logic [31:0] imm, input logic br);
        exp_t e;
        e.op1 = op1; e.op2 = op2; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm; e.br = br;
        return e;
    endfunction

    // Reference for W=32, R=5, IMM=9: fields at [23:19], [18:14], [13:9], imm [8:0].
    function automatic exp_t model_b(input logic [31:0] i);
        exp_t e;
        e.op1 = i[31:28];
        e.op2 = i[27:24];
        e.br  = (i[31:30] == 2'b01);
        e.rd  = {3'b000, i[23:19]};
        e.rs1 = e.br ? {3'b000, i[23:19]} : {3'b000, i[18:14]};
        e.rs2 = e.br ? {3'b000, i[18:14]} : {3'b000, i[13:9]};
        e.imm = {{23{i[8]}}, i[8:0]};
        if (e.br) e.imm = {e.imm[29:0], 2'b00};
        return e;
    endfunction

    always @(negedge clk) begin
        if (a_reset) begin
            a_cnt_exp = 4'd0;
        end else if (a_out_valid && a_out_ready) begin
            if (qa.size() == 0) chk("a_spurious_out", 64'd1, 64'd0);
            else begin
                a_e = qa.pop_front();
                chk_rec("a_out", a_e, a_op1, a_op2, 8'(a_rd), 8'(a_rs1), 8'(a_rs2), a_imm, a_is_branch);
            end
            chk("a_count", 64'(a_count), 64'(a_cnt_exp));
            a_cnt_exp = a_cnt_exp + 4'd1;
        end
    end

    always @(negedge clk) begin
        if (b_reset) begin
            b_cnt_exp = 16'd0;
        end else if (b_out_valid && b_out_ready) begin
            if (qb.size() == 0) chk("b_spurious_out", 64'd1, 64'd0);
            else begin
                b_e = qb.pop_front();
                chk_rec("b_out", b_e, b_op1, b_op2, 8'(b_rd), 8'(b_rs1), 8'(b_rs2), b_imm, b_is_branch);
            end
            chk("b_count", 64'(b_count), 64'(b_cnt_exp));
            b_cnt_exp = b_cnt_exp + 16'd1;
        end
    end

    // One cycle on A; returns just after the next rising edge.
    task automatic step_a(input logic v, input logic [31:0] ins, input logic rdy, input logic fl,
                          input exp_t e, output logic acc);
        a_in_valid = v; a_in_instr = ins; a_out_ready = rdy; a_flush = fl;
        @(negedge clk);
        acc = v && a_in_ready && !fl;
        if (acc) qa.push_back(e);
        if (fl) begin #1; qa.delete(); end
        @(posedge clk); #1;
    endtask

    task automatic step_b(input logic v, input logic [31:0] ins, input logic rdy, input logic rs,
                          input exp_t e, output logic acc);
        b_in_valid = v; b_in_instr = ins; b_out_ready = rdy; b_reset = rs;
        @(negedge clk);
        acc = v && b_in_ready && !rs;
        if (acc) qb.push_back(e);
        if (rs) begin #1; qb.delete(); end
        @(posedge clk); #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] vec_i [5];
    exp_t        vec_e [5];

    initial begin
        logic        acc;
        logic [31:0] ins;
        int          n_acc, cyc;

        vec_i[0] = 32'h12345678; vec_e[0] = mk(4'h1, 4'h2, 8'h3, 8'h4, 8'h5, 32'h00005678, 1'b0);
        vec_i[1] = 32'h4A3B8004; vec_e[1] = mk(4'h4, 4'hA, 8'h3, 8'h3, 8'hB, 32'hFFFE0010, 1'b1);
        vec_i[2] = 32'h7FFF0001; vec_e[2] = mk(4'h7, 4'hF, 8'hF, 8'hF, 8'hF, 32'h00000004, 1'b1);
        vec_i[3] = 32'h8C010FFF; vec_e[3] = mk(4'h8, 4'hC, 8'h0, 8'h1, 8'h0, 32'h00000FFF, 1'b0);
        vec_i[4] = 32'hFEDC8000; vec_e[4] = mk(4'hF, 4'hE, 8'hD, 8'hC, 8'h8, 32'hFFFF8000, 1'b0);
        dummy = mk(4'h0, 4'h0, 8'h0, 8'h0, 8'h0, 32'h0, 1'b0);

        a_reset = 1'b1; a_flush = 1'b0; a_in_valid = 1'b0; a_in_instr = '0; a_out_ready = 1'b0;
        b_reset = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_in_instr = '0; b_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_in_ready",  64'(a_in_ready),  64'd0);
        chk("rst_count",     64'(a_count),     64'd0);
        chk("rst_imm",       64'(a_imm),       64'd0);
        chk("rst_op1",       64'(a_op1),       64'd0);
        chk("rst_rd",        64'(a_rd),        64'd0);
        a_reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready",  64'(a_in_ready),  64'd1);
        chk("post_rst_out_valid", 64'(a_out_valid), 64'd0);

        // Non-branch and branch decodes, one-cycle latency.
        step_a(1'b1, vec_i[0], 1'b1, 1'b0, vec_e[0], acc);
        chk("t1_acc", 64'(acc), 64'd1);
        chk("t1_valid", 64'(a_out_valid), 64'd1);
        step_a(1'b0, '0, 1'b1, 1'b0, dummy, acc);
        chk("t1_count", 64'(a_count), 64'd1);
        step_a(1'b1, vec_i[1], 1'b1, 1'b0, vec_e[1], acc);
        chk("t2_valid", 64'(a_out_valid), 64'd1);
        step_a(1'b0, '0, 1'b1, 1'b0, dummy, acc);
        chk("t2_count", 64'(a_count), 64'd2);

        // Back-pressure: I0 held, I1 in skid, I2 refused until release.
        step_a(1'b1, vec_i[0], 1'b0, 1'b0, vec_e[0], acc);
        chk("bp_i0_acc", 64'(acc), 64'd1);
        chk_rec("bp_hold1", vec_e[0], a_op1, a_op2, 8'(a_rd), 8'(a_rs1), 8'(a_rs2), a_imm, a_is_branch);
        step_a(1'b1, vec_i[1], 1'b0, 1'b0, vec_e[1], acc);
        chk("bp_i1_acc", 64'(acc), 64'd1);
        chk("bp_full_ready", 64'(a_in_ready), 64'd0);
        chk_rec("bp_hold2", vec_e[0], a_op1, a_op2, 8'(a_rd), 8'(a_rs1), 8'(a_rs2), a_imm, a_is_branch);
        step_a(1'b1, vec_i[2], 1'b0, 1'b0, vec_e[2], acc);
        chk("bp_i2_refused", 64'(acc), 64'd0);
        step_a(1'b1, vec_i[2], 1'b0, 1'b0, vec_e[2], acc);
        chk("bp_i2_refused2", 64'(acc), 64'd0);
        chk("bp_still_full", 64'(a_in_ready), 64'd0);
        chk_rec("bp_hold3", vec_e[0], a_op1, a_op2, 8'(a_rd), 8'(a_rs1), 8'(a_rs2), a_imm, a_is_branch);
        acc = 1'b0;
        for (int k = 0; k < 5 && !acc; k++) step_a(1'b1, vec_i[2], 1'b1, 1'b0, vec_e[2], acc);
        chk("bp_i2_acc", 64'(acc), 64'd1);
        repeat (3) step_a(1'b0, '0, 1'b1, 1'b0, dummy, acc);
        chk("bp_count", 64'(a_count), 64'd5);

        // Flush with both entries full and a fresh instruction offered.
        step_a(1'b1, vec_i[3], 1'b0, 1'b0, vec_e[3], acc);
        step_a(1'b1, vec_i[4], 1'b0, 1'b0, vec_e[4], acc);
        chk("fl_full_ready", 64'(a_in_ready), 64'd0);
        step_a(1'b1, 32'h11111111, 1'b0, 1'b1, dummy, acc);
        chk("fl_out_valid", 64'(a_out_valid), 64'd0);
        chk("fl_in_ready",  64'(a_in_ready),  64'd1);
        chk("fl_count",     64'(a_count),     64'd5);
        step_a(1'b0, '0, 1'b1, 1'b0, dummy, acc);
        chk("fl_nothing_after", 64'(a_out_valid), 64'd0);

        // Full-rate stream; 12 more transfers bring the 4-bit count to 17 mod 16.
        for (int k = 0; k < 12; k++) begin
            step_a(1'b1, vec_i[k % 5], 1'b1, 1'b0, vec_e[k % 5], acc);
            chk("stream_acc", 64'(acc), 64'd1);
        end
        repeat (2) step_a(1'b0, '0, 1'b1, 1'b0, dummy, acc);
        chk("wrap_count", 64'(a_count), 64'd1);
        chk("a_queue_empty", 64'(qa.size()), 64'd0);

        // Random stream on B with a reset in the middle.
        b_reset = 1'b0;
        n_acc = 0;
        cyc = 0;
        while (n_acc < 10000 && cyc < 60000) begin
            ins = $urandom();
            if (cyc == 3000) begin
                step_b(1'b1, ins, 1'b1, 1'b1, model_b(ins), acc);
                chk("b_mid_reset_valid", 64'(b_out_valid), 64'd0);
                b_reset = 1'b0;
            end else begin
                step_b($urandom_range(0, 3) != 0, ins, $urandom_range(0, 2) != 0, 1'b0, model_b(ins), acc);
            end
            if (acc) n_acc++;
            cyc++;
        end
        chk("b_budget", 64'(n_acc >= 10000), 64'd1);
        repeat (4) step_b(1'b0, '0, 1'b1, 1'b0, dummy, acc);
        chk("b_queue_empty", 64'(qb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction-decode pipeline stage with valid/ready handshakes on both sides. It splits each instruction into opcode, register and immediate fields, extends and scales the immediate, and flags branch-format instructions. A two-entry skid buffer gives full throughput under back-pressure while keeping `in_ready` registered. It sits between fetch and register-file read and replaces the purely combinational field decoder.

## Interface
Parameters:
- `INSTR_WIDTH`, 32: instruction width.
- `REG_WIDTH`, 4: register-specifier width.
- `IMM_WIDTH`, 16: raw immediate width, taken from `instr[IMM_WIDTH-1:0]`.
- `DATA_WIDTH`, 32: width of the extended immediate.
- `BR_SHIFT`, 2: left shift applied to branch immediates.
- `COUNT_WIDTH`, 16: width of the decoded-instruction counter.

Ports:
- `clk`  in  1  sole clock. One clock; reset is synchronous and active-high.
- `reset`  in  1  synchronous, active-high.
- `flush`  in  1  discard all held instructions.
- `in_valid`  in  1  fetch offers `in_instr`.
- `in_ready`  out  1  stage can accept; registered.
- `in_instr`  in  INSTR_WIDTH  raw instruction.
- `out_valid`  out  1  decoded entry present.
- `out_ready`  in  1  downstream accepts.
- `out_op1`, `out_op2`  out  4  primary and secondary opcode.
- `out_rd`, `out_rs1`, `out_rs2`  out  REG_WIDTH  register specifiers.
- `out_imm`  out  DATA_WIDTH  extended (and, for branches, scaled) immediate.
- `out_is_branch`  out  1  branch-format instruction.
- `out_count`  out  COUNT_WIDTH  count of completed output transfers.

## Operation
Field layout, packed from the MSB, with `W = INSTR_WIDTH`, `R = REG_WIDTH`:
- `op1 = instr[W-1:W-4]`.
- `op2 = instr[W-5:W-8]`.
- field A = `instr[W-9 -: R]`, field B = the next R bits, field C = the next R bits.
- `rd` = A.
- Branch format (`op1[3:2] == 2'b01`): `rs1` = A, `rs2` = B.
- Otherwise: `rs1` = B, `rs2` = C.

Immediate:
- Sign-extend `instr[IMM_WIDTH-1:0]` to `DATA_WIDTH`.
- If branch, shift left by `BR_SHIFT` and truncate to `DATA_WIDTH`.
- Fields C and imm may overlap; this is legal.

Elaboration checks (fatal):
- `W >= 8 + 3*R`.
- `IMM_WIDTH <= DATA_WIDTH`.

Decoding happens on input, before storage. Each entry holds the full decoded record.

Buffer behaviour:
- Entry 0 is the output register; entry 1 is the skid register.
- Input transfer: `in_valid && in_ready`. Output transfer: `out_valid && out_ready`.
- Empty → entry 0 loads.
- Entry 0 full, output transfer in the same cycle → entry 0 reloads.
- Entry 0 full, output stalled → entry 1 loads.
- When entry 0 drains and entry 1 is full, entry 1 moves to entry 0.
- `in_ready` next-state = !(entry 1 will be full).

`out_count`:
- Increments on every output transfer.
- Wraps modulo 2^COUNT_WIDTH.
- Unaffected by `flush`.

Flush:
- Both entries become empty next cycle, and `in_ready` becomes 1 next cycle.
- An input transfer in the flush cycle is discarded.
- An output transfer in the flush cycle still counts: the downstream saw it.

## Timing
- Latency: instruction accepted in cycle N appears on the outputs in cycle N+1.
- Throughput: one instruction per cycle with `out_ready` held high.
- Reset values:
  - `out_valid` = 0, `in_ready` = 0 during reset, 1 the first cycle after.
  - All decoded outputs = 0, `out_count` = 0.
- Reset mid-operation drops all entries. Reset dominates `flush`.
- Output stability: while `out_valid && !out_ready`, all `out_*` fields hold stable.
- Full: with both entries occupied, `in_ready` = 0. Entry 1 never overwrites.
- Simultaneous input and output transfer while entry 0 alone is full: entry 0 replaced, entry 1 stays empty.
- Simultaneous events with both entries full: entry 1 → entry 0, and `in_ready` returns to 1 next cycle (ready was 0, so no input is accepted that cycle).

## Structure
Package `decode_pkg` holds:
- `OP_W = 4`.
- `BRANCH_OP1_PREFIX = 2'b01`.
- Parametrised field-offset functions.
- `decoded_t` record struct: op1, op2, rd, rs1, rs2, imm, is_branch.

Sub-modules:
- `decode_skid`: a generic two-entry registered-ready skid buffer over `decoded_t`, including flush.
- Field decode is a function in the package.

## Test plan
- Non-branch, defaults: `0x12345678`, `out_ready=1` → next cycle op1=1, op2=2, rd=3, rs1=4, rs2=5, imm=`0x00005678`, is_branch=0, count=1.
- Branch: `0x4A3B8004` → op1=4, op2=A, rd=3, rs1=3, rs2=B, imm=`0xFFFE0010`, is_branch=1.
- Back-pressure:
  - Send I0, I1, I2 back-to-back with `out_ready=0` → I0 held stable, I1 in skid, `in_ready=0` from the cycle after I1 is accepted, I2 not accepted.
  - Release `out_ready` → order I0, I1, I2, no loss or duplication.
- Flush with both entries full plus `in_valid=1` → next cycle `out_valid=0`, `in_ready=1`, flushed instruction never appears, count unchanged.
- Count wrap: `COUNT_WIDTH=4`, 17 transfers → `out_count=1`.
- Parameter sweep: REG_WIDTH=5, INSTR_WIDTH=32, IMM_WIDTH=9 against a reference model on 10k random instructions under random handshakes. Also assert reset mid-stream gives `out_valid=0` next cycle.
